// File: rtl/axi_rd_arbiter.sv
// Read-port arbiter between instruction fetch and data load for the AXI bridge.
// One read outstanding; responses routed by ID, flushed fetch responses dropped.
module axi_rd_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [2:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_addr,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    input  logic        wr_busy,
    input  logic [31:0] wr_addr,
    output logic        br_rd_req,
    output logic [3:0]  br_rd_id,
    output logic [2:0]  br_rd_size,
    output logic [31:0] br_rd_addr,
    input  logic        br_rd_addr_ok,
    input  logic        br_rd_rvalid,
    input  logic [3:0]  br_rd_rid,
    input  logic [31:0] br_rd_rdata,
    input  logic        excp_flush,
    input  logic        ertn_flush
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] streak;
    logic       drop;

    logic flush;
    logic hazard;
    logic d_elig;
    logic i_elig;
    logic starve;
    logic grant_d;
    logic grant_i;
    logic accept;
    logic is_inst;
    logic unused_wr_lsb;

    assign flush   = excp_flush | ertn_flush;
    assign hazard  = wr_busy && (wr_addr[31:2] == data_addr[31:2]);
    assign d_elig  = data_req && !hazard;
    assign i_elig  = inst_req && !flush;
    assign starve  = (streak == SMAX) && i_elig;
    assign grant_d = (state == IDLE) && d_elig && !starve;
    assign grant_i = (state == IDLE) && i_elig && !grant_d;
    assign is_inst = (br_rd_id == ID_INST);
    assign accept  = (state == WAIT) && br_rd_rvalid && (br_rd_rid == br_rd_id);

    assign unused_wr_lsb = ^wr_addr[1:0];

    assign inst_addr_ok = br_rd_addr_ok && (state == ADDR) && (br_rd_id == ID_INST);
    assign data_addr_ok = br_rd_addr_ok && (state == ADDR) && (br_rd_id == ID_DATA);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_d || grant_i) state_nxt = ADDR;
            ADDR:    if (br_rd_addr_ok) state_nxt = WAIT;
            WAIT:    if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            br_rd_req    <= 1'b0;
            br_rd_id     <= 4'd0;
            br_rd_size   <= 3'd0;
            br_rd_addr   <= 32'd0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            inst_rdata   <= 32'd0;
            data_rdata   <= 32'd0;
            streak       <= 4'd0;
            drop         <= 1'b0;
        end else begin
            state        <= state_nxt;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;

            if (grant_d || grant_i) begin
                br_rd_req  <= 1'b1;
                br_rd_id   <= grant_d ? ID_DATA : ID_INST;
                br_rd_size <= grant_d ? data_size : inst_size;
                br_rd_addr <= grant_d ? data_addr : inst_addr;
            end else if ((state == ADDR) && br_rd_addr_ok) begin
                br_rd_req <= 1'b0;
            end

            // a flush in the accepting cycle still suppresses the fetch result
            if (accept) begin
                if (!is_inst) begin
                    data_rdata   <= br_rd_rdata;
                    data_data_ok <= 1'b1;
                end else if (!drop && !flush) begin
                    inst_rdata   <= br_rd_rdata;
                    inst_data_ok <= 1'b1;
                end
            end

            if ((state == IDLE) || accept) begin
                drop <= 1'b0;
            end else if (flush && is_inst) begin
                drop <= 1'b1;
            end

            if (!inst_req || grant_i) begin
                streak <= 4'd0;
            end else if (grant_d && (streak != SMAX)) begin
                streak <= streak + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus a
// response scoreboard fed at stimulus time and drained on *_data_ok.
module tb_axi_rd_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [2:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [2:0]  data_size;
    logic [31:0] data_addr;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        wr_busy;
    logic [31:0] wr_addr;
    logic        br_rd_req;
    logic [3:0]  br_rd_id;
    logic [2:0]  br_rd_size;
    logic [31:0] br_rd_addr;
    logic        br_rd_addr_ok;
    logic        br_rd_rvalid;
    logic [3:0]  br_rd_rid;
    logic [31:0] br_rd_rdata;
    logic        excp_flush;
    logic        ertn_flush;

    int checks = 0;
    int failures = 0;

    logic [31:0] inst_q[$];
    logic [31:0] data_q[$];

    axi_rd_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk),
        .reset(reset),
        .inst_req(inst_req),
        .inst_size(inst_size),
        .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req),
        .data_size(data_size),
        .data_addr(data_addr),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .wr_busy(wr_busy),
        .wr_addr(wr_addr),
        .br_rd_req(br_rd_req),
        .br_rd_id(br_rd_id),
        .br_rd_size(br_rd_size),
        .br_rd_addr(br_rd_addr),
        .br_rd_addr_ok(br_rd_addr_ok),
        .br_rd_rvalid(br_rd_rvalid),
        .br_rd_rid(br_rd_rid),
        .br_rd_rdata(br_rd_rdata),
        .excp_flush(excp_flush),
        .ertn_flush(ertn_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard drain: every data_ok pulse must match the oldest expectation
    always @(posedge clk) begin
        logic [31:0] e;
        #1;
        if (!reset) begin
            if (inst_data_ok) begin
                checks++;
                if (inst_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_inst: unexpected inst_data_ok rdata=%h", inst_rdata);
                end else begin
                    e = inst_q.pop_front();
                    if (inst_rdata !== e) begin
                        failures++;
                        $display("FAIL sb_inst: got %h exp %h", inst_rdata, e);
                    end
                end
            end
            if (data_data_ok) begin
                checks++;
                if (data_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_data: unexpected data_data_ok rdata=%h", data_rdata);
                end else begin
                    e = data_q.pop_front();
                    if (data_rdata !== e) begin
                        failures++;
                        $display("FAIL sb_data: got %h exp %h", data_rdata, e);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        inst_req = 1'b0; inst_size = 3'd0; inst_addr = 32'd0;
        data_req = 1'b0; data_size = 3'd0; data_addr = 32'd0;
        wr_busy = 1'b0; wr_addr = 32'd0;
        br_rd_addr_ok = 1'b0; br_rd_rvalid = 1'b0;
        br_rd_rid = 4'd0; br_rd_rdata = 32'd0;
        excp_flush = 1'b0; ertn_flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_req(input logic [3:0] id, input logic [31:0] addr,
                            input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (br_rd_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout: br_rd_req got 0 exp 1", tag);
        end else begin
            checks++;
            if (br_rd_id !== id || br_rd_addr !== addr) begin
                failures++;
                $display("FAIL %s_grant: got id=%0d addr=%h exp id=%0d addr=%h",
                         tag, br_rd_id, br_rd_addr, id, addr);
            end
        end
    endtask

    task automatic do_addr(input logic [3:0] id, input string tag);
        logic ei;
        logic ed;
        ei = (id == 4'd0);
        ed = (id == 4'd1);
        br_rd_addr_ok = 1'b1;
        #1;
        checks++;
        if (inst_addr_ok !== ei || data_addr_ok !== ed) begin
            failures++;
            $display("FAIL %s_addr_ok: got i=%b d=%b exp i=%b d=%b",
                     tag, inst_addr_ok, data_addr_ok, ei, ed);
        end
        @(negedge clk);
        br_rd_addr_ok = 1'b0;
        checks++;
        if (br_rd_req !== 1'b0) begin
            failures++;
            $display("FAIL %s_req_drop: br_rd_req got %b exp 0", tag, br_rd_req);
        end
    endtask

    task automatic do_resp(input logic [3:0] rid, input logic [31:0] d);
        br_rd_rvalid = 1'b1;
        br_rd_rid = rid;
        br_rd_rdata = d;
        @(negedge clk);
        br_rd_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        br_rd_addr_ok = 1'b1;
        inst_req = 1'b1;
        data_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (br_rd_req !== 1'b0 || br_rd_id !== 4'd0 || br_rd_addr !== 32'd0 ||
            br_rd_size !== 3'd0) begin
            failures++;
            $display("FAIL reset_br: got req=%b id=%0d addr=%h size=%0d exp 0",
                     br_rd_req, br_rd_id, br_rd_addr, br_rd_size);
        end
        checks++;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 ||
            inst_rdata !== 32'd0 || data_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_resp: got iok=%b dok=%b ird=%h drd=%h exp 0",
                     inst_data_ok, data_data_ok, inst_rdata, data_rdata);
        end
        checks++;
        if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL reset_addr_ok: got i=%b d=%b exp 0 0",
                     inst_addr_ok, data_addr_ok);
        end
        br_rd_addr_ok = 1'b0;
        inst_req = 1'b0;
        data_req = 1'b0;
    endtask

    task automatic test_single_inst();
        do_reset();
        inst_size = 3'd2;
        inst_addr = 32'h1c00_0000;
        inst_req = 1'b1;
        wait_req(4'd0, 32'h1c00_0000, "t1");
        checks++;
        if (br_rd_size !== 3'd2) begin
            failures++;
            $display("FAIL t1_size: got %0d exp 2", br_rd_size);
        end
        do_addr(4'd0, "t1");
        inst_req = 1'b0;
        inst_q.push_back(32'hDEAD_BEEF);
        do_resp(4'd0, 32'hDEAD_BEEF);
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL t1_data: got ok=%b rdata=%h exp ok=1 rdata=deadbeef",
                     inst_data_ok, inst_rdata);
        end
        @(negedge clk);
        checks++;
        if (inst_data_ok !== 1'b0) begin
            failures++;
            $display("FAIL t1_pulse: inst_data_ok got %b exp 0", inst_data_ok);
        end
    endtask

    task automatic test_starve();
        logic [3:0] order [10];
        logic [31:0] a;
        order = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0};
        do_reset();
        inst_addr = 32'h0000_1000;
        data_addr = 32'h0000_2000;
        inst_size = 3'd2;
        data_size = 3'd2;
        inst_req = 1'b1;
        data_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = (order[i] == 4'd1) ? 32'h0000_2000 : 32'h0000_1000;
            wait_req(order[i], a, $sformatf("t2_%0d", i));
            do_addr(order[i], $sformatf("t2_%0d", i));
            if (order[i] == 4'd1) data_q.push_back(32'hA000_0000 + 32'(i));
            else inst_q.push_back(32'hA000_0000 + 32'(i));
            do_resp(order[i], 32'hA000_0000 + 32'(i));
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hazard();
        do_reset();
        wr_busy = 1'b1;
        wr_addr = 32'h0000_0100;
        data_addr = 32'h0000_0102;
        data_req = 1'b1;
        inst_addr = 32'h0000_0200;
        inst_req = 1'b1;
        wait_req(4'd0, 32'h0000_0200, "t3_inst");
        do_addr(4'd0, "t3_inst");
        inst_req = 1'b0;
        inst_q.push_back(32'h1111_2222);
        do_resp(4'd0, 32'h1111_2222);
        repeat (3) @(negedge clk);
        checks++;
        if (br_rd_req !== 1'b0) begin
            failures++;
            $display("FAIL t3_hold: br_rd_req got %b exp 0", br_rd_req);
        end
        wr_busy = 1'b0;
        wait_req(4'd1, 32'h0000_0102, "t3_data");
        do_addr(4'd1, "t3_data");
        data_req = 1'b0;
        data_q.push_back(32'h3333_4444);
        do_resp(4'd1, 32'h3333_4444);
        @(negedge clk);
    endtask

    task automatic test_flush();
        do_reset();
        inst_addr = 32'h0000_0020;
        inst_req = 1'b1;
        wait_req(4'd0, 32'h0000_0020, "t4_a");
        do_addr(4'd0, "t4_a");
        inst_req = 1'b0;
        inst_q.push_back(32'hCAFE_0001);
        do_resp(4'd0, 32'hCAFE_0001);

        inst_addr = 32'h0000_0040;
        inst_req = 1'b1;
        wait_req(4'd0, 32'h0000_0040, "t4_b");
        do_addr(4'd0, "t4_b");
        inst_req = 1'b0;
        excp_flush = 1'b1;
        @(negedge clk);
        excp_flush = 1'b0;
        do_resp(4'd0, 32'hBAD0_BAD0);
        checks++;
        if (inst_data_ok !== 1'b0 || inst_rdata !== 32'hCAFE_0001) begin
            failures++;
            $display("FAIL t4_drop: got ok=%b rdata=%h exp ok=0 rdata=cafe0001",
                     inst_data_ok, inst_rdata);
        end
        data_addr = 32'h0000_0500;
        data_req = 1'b1;
        @(negedge clk);
        checks++;
        if (br_rd_req !== 1'b1 || br_rd_id !== 4'd1) begin
            failures++;
            $display("FAIL t4_idle: got req=%b id=%0d exp req=1 id=1",
                     br_rd_req, br_rd_id);
        end
        do_addr(4'd1, "t4_d");
        data_req = 1'b0;
        data_q.push_back(32'h5A5A_5A5A);
        do_resp(4'd1, 32'h5A5A_5A5A);

        inst_addr = 32'h0000_0080;
        inst_req = 1'b1;
        wait_req(4'd0, 32'h0000_0080, "t4_c");
        do_addr(4'd0, "t4_c");
        inst_req = 1'b0;
        ertn_flush = 1'b1;
        do_resp(4'd0, 32'hBAD1_BAD1);
        ertn_flush = 1'b0;
        checks++;
        if (inst_data_ok !== 1'b0 || inst_rdata !== 32'hCAFE_0001) begin
            failures++;
            $display("FAIL t4_coinc: got ok=%b rdata=%h exp ok=0 rdata=cafe0001",
                     inst_data_ok, inst_rdata);
        end

        inst_addr = 32'h0000_00c0;
        inst_req = 1'b1;
        wait_req(4'd0, 32'h0000_00c0, "t4_e");
        do_addr(4'd0, "t4_e");
        inst_req = 1'b0;
        inst_q.push_back(32'hCAFE_0002);
        do_resp(4'd0, 32'hCAFE_0002);
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'hCAFE_0002) begin
            failures++;
            $display("FAIL t4_after: got ok=%b rdata=%h exp ok=1 rdata=cafe0002",
                     inst_data_ok, inst_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_rid_filter();
        do_reset();
        data_addr = 32'h0000_0300;
        data_req = 1'b1;
        wait_req(4'd1, 32'h0000_0300, "t5");
        do_addr(4'd1, "t5");
        data_req = 1'b0;
        do_resp(4'd0, 32'h0000_00AA);
        checks++;
        if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
            failures++;
            $display("FAIL t5_ignore: got dok=%b iok=%b exp 0 0",
                     data_data_ok, inst_data_ok);
        end
        data_q.push_back(32'h0000_0055);
        do_resp(4'd1, 32'h0000_0055);
        checks++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'h0000_0055) begin
            failures++;
            $display("FAIL t5_data: got ok=%b rdata=%h exp ok=1 rdata=00000055",
                     data_data_ok, data_rdata);
        end
        @(negedge clk);
        checks++;
        if (data_data_ok !== 1'b0) begin
            failures++;
            $display("FAIL t5_pulse: data_data_ok got %b exp 0", data_data_ok);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        inst_addr = 32'h0000_0060;
        inst_req = 1'b1;
        wait_req(4'd0, 32'h0000_0060, "t6");
        reset = 1'b1;
        inst_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (br_rd_req !== 1'b0) begin
            failures++;
            $display("FAIL t6_req: br_rd_req got %b exp 0", br_rd_req);
        end
        do_resp(4'd0, 32'h7777_7777);
        do_resp(4'd1, 32'h8888_8888);
        @(negedge clk);
        checks++;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 ||
            inst_rdata !== 32'd0 || data_rdata !== 32'd0) begin
            failures++;
            $display("FAIL t6_late: got iok=%b dok=%b ird=%h drd=%h exp 0",
                     inst_data_ok, data_data_ok, inst_rdata, data_rdata);
        end
    endtask

    initial begin
        reset = 1'b1;
        do_reset();
        test_reset();
        test_single_inst();
        test_starve();
        test_hazard();
        test_flush();
        test_rid_filter();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (inst_q.size() != 0 || data_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: pending inst=%0d data=%0d exp 0 0",
                     inst_q.size(), data_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
